// File: rtl/vga_frame_checker.sv
// Passive VGA sink: samples one pixel per rising VGA_CLK edge and measures line and frame timing.
// It also builds a per-frame RGB checksum and exposes the results over an Avalon-MM slave with read latency 1.
module vga_frame_checker #(
  parameter int unsigned EXP_HACTIVE = 640,
  parameter int unsigned EXP_VACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        frame_done
);

  localparam logic [15:0] EXP_H16 = EXP_HACTIVE[15:0];
  localparam logic [15:0] EXP_V16 = EXP_VACTIVE[15:0];

  typedef enum logic {SEEK, CAPTURE} state_t;
  state_t state;

  logic        vga_clk_q, hs_q, vs_q, blank_q;
  logic [15:0] hcnt, vcnt, hmin_acc, hmax_acc;
  logic [31:0] chk_acc;
  logic [15:0] hmin, hmax, vact, htot, htcnt;
  logic        hs_seen;
  logic [31:0] chk, frame_count;
  logic        frame_valid, hact_err, vact_err;
  logic [31:0] rd_mux;

  logic pe, vs_fall, hs_fall, blank_fall, frame_end;
  logic wr0, clr_err, clr_cnt, hact_set, vact_set;
  logic unused_wdata;

  assign pe         = vga_clk & ~vga_clk_q;
  assign vs_fall    = pe & vs_q & ~vga_vs;
  assign hs_fall    = pe & hs_q & ~vga_hs;
  assign blank_fall = pe & blank_q & ~vga_blank_n;
  assign frame_end  = vs_fall & (state == CAPTURE);

  assign wr0      = chipselect & write & (address == 3'd0);
  assign clr_err  = wr0 & writedata[0];
  assign clr_cnt  = wr0 & writedata[1];
  assign hact_set = blank_fall & (state == CAPTURE) & (hcnt != EXP_H16);
  assign vact_set = frame_end & (vcnt != EXP_V16);
  assign unused_wdata = ^writedata[31:2];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = {frame_count[15:0], 13'b0, vact_err, hact_err, frame_valid};
      3'd1:    rd_mux = {hmax, hmin};
      3'd2:    rd_mux = {16'b0, vact};
      3'd3:    rd_mux = {16'b0, htot};
      3'd4:    rd_mux = chk;
      3'd5:    rd_mux = frame_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEEK;
      vga_clk_q   <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      blank_q     <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hmin_acc    <= '0;
      hmax_acc    <= '0;
      chk_acc     <= '0;
      hmin        <= '0;
      hmax        <= '0;
      vact        <= '0;
      htot        <= '0;
      htcnt       <= '0;
      hs_seen     <= 1'b0;
      chk         <= '0;
      frame_count <= '0;
      frame_valid <= 1'b0;
      hact_err    <= 1'b0;
      vact_err    <= 1'b0;
      readdata    <= '0;
      frame_done  <= 1'b0;
    end else begin
      vga_clk_q  <= vga_clk;
      frame_done <= frame_end;
      if (pe) begin
        hs_q    <= vga_hs;
        vs_q    <= vga_vs;
        blank_q <= vga_blank_n;
      end

      // htot tracks HS period independently of frame capture
      if (hs_fall) begin
        htcnt   <= 16'd1;
        hs_seen <= 1'b1;
        if (hs_seen) htot <= htcnt;
      end else if (pe) begin
        htcnt <= sat_inc(htcnt);
      end

      case (state)
        SEEK: begin
          if (vs_fall) begin
            state    <= CAPTURE;
            hcnt     <= '0;
            vcnt     <= '0;
            hmin_acc <= '1;
            hmax_acc <= '0;
            chk_acc  <= '0;
          end
        end
        CAPTURE: begin
          if (vs_fall) begin
            hmin     <= hmin_acc;
            hmax     <= hmax_acc;
            vact     <= vcnt;
            chk      <= chk_acc;
            hcnt     <= '0;
            vcnt     <= '0;
            hmin_acc <= '1;
            hmax_acc <= '0;
            chk_acc  <= '0;
          end else if (pe) begin
            if (vga_blank_n) begin
              hcnt    <= sat_inc(hcnt);
              chk_acc <= {chk_acc[30:0], chk_acc[31]} ^ {8'h00, vga_r, vga_g, vga_b};
            end else if (blank_fall) begin
              hcnt <= '0;
              vcnt <= sat_inc(vcnt);
              if (hcnt < hmin_acc) hmin_acc <= hcnt;
              if (hcnt > hmax_acc) hmax_acc <= hcnt;
            end
          end
        end
        default: state <= SEEK;
      endcase

      // error set wins over a same-cycle software clear
      hact_err <= hact_set | (hact_err & ~clr_err);
      vact_err <= vact_set | (vact_err & ~clr_err);

      if (frame_end) begin
        frame_valid <= 1'b1;
        frame_count <= clr_cnt ? 32'd1 : frame_count + 32'd1;
      end else if (clr_cnt) begin
        frame_count <= '0;
      end

      if (chipselect & read) readdata <= rd_mux;
    end
  end

endmodule
